// File: rtl/palette_fade_ctrl.sv
// Palette brightness sequencer: scales lookup colour by a 0..16 level, frame-paced fades/flash.
// Optional: PALETTE_FADE_TRANSPARENT_EN lets index 0 bypass scaling and flash.
module palette_fade_ctrl #(
  parameter int unsigned STEP_FRAMES  = 2,
  parameter int unsigned FLASH_FRAMES = 4
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_tick,
  input  logic       cmd_valid,
  input  logic [1:0] cmd,
  output logic       cmd_ready,
  input  logic [3:0] index,
  input  logic [3:0] in_red,
  input  logic [3:0] in_green,
  input  logic [3:0] in_blue,
  output logic [3:0] out_red,
  output logic [3:0] out_green,
  output logic [3:0] out_blue,
  output logic [4:0] level,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    BRIGHT,
    FADE_OUT,
    DARK,
    FADE_IN,
    FLASH
  } state_t;

  localparam logic [3:0] STEP_LAST  = 4'(STEP_FRAMES - 1);
  localparam logic [3:0] FLASH_LAST = 4'(FLASH_FRAMES - 1);

`ifdef PALETTE_FADE_TRANSPARENT_EN
  localparam logic TRANSP = 1'b1;
`else
  localparam logic TRANSP = 1'b0;
`endif

  state_t     state, state_nxt;
  logic [4:0] level_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       done_nxt;
  logic       accept;
  logic       step;
  logic       is_fo, is_fi, is_fl;

  assign cmd_ready = (state == BRIGHT) | (state == DARK);
  assign busy      = ~cmd_ready;
  assign accept    = cmd_valid & cmd_ready;
  assign step      = frame_tick & (cnt == STEP_LAST);

  assign is_fo = (cmd == 2'b01);
  assign is_fi = (cmd == 2'b10);
  assign is_fl = (cmd == 2'b11);

  always_comb begin
    state_nxt = state;
    level_nxt = level;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    case (state)
      BRIGHT: begin
        if (accept) begin
          cnt_nxt = 4'd0;
          unique case (1'b1)
            is_fo:   state_nxt = FADE_OUT;
            is_fl:   state_nxt = FLASH;
            default: state_nxt = BRIGHT;
          endcase
        end
      end
      DARK: begin
        if (accept) begin
          cnt_nxt = 4'd0;
          if (is_fi) state_nxt = FADE_IN;
        end
      end
      FADE_OUT: begin
        if (step) begin
          cnt_nxt   = 4'd0;
          level_nxt = level - 5'd1;
          if (level == 5'd1) begin
            state_nxt = DARK;
            done_nxt  = 1'b1;
          end
        end else if (frame_tick) begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      FADE_IN: begin
        if (step) begin
          cnt_nxt   = 4'd0;
          level_nxt = level + 5'd1;
          if (level == 5'd15) begin
            state_nxt = BRIGHT;
            done_nxt  = 1'b1;
          end
        end else if (frame_tick) begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      FLASH: begin
        if (frame_tick) begin
          if (cnt == FLASH_LAST) begin
            cnt_nxt   = 4'd0;
            state_nxt = BRIGHT;
            done_nxt  = 1'b1;
          end else begin
            cnt_nxt = cnt + 4'd1;
          end
        end
      end
      default: begin
        state_nxt = BRIGHT;
        level_nxt = 5'd16;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= BRIGHT;
      level <= 5'd16;
      cnt   <= 4'd0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      level <= level_nxt;
      cnt   <= cnt_nxt;
      done  <= done_nxt;
    end
  end

  // 4b colour x 5b level fits an 8b product since level never exceeds 16
  function automatic logic [3:0] scale(
    input logic [3:0] c,
    input logic [4:0] l
  );
    logic [7:0] p;
    p = 8'(c) * 8'(l);
    return p[7:4];
  endfunction

  logic       bypass;
  logic       white;
  logic [3:0] r_nxt, g_nxt, b_nxt;

  assign bypass = TRANSP & (index == 4'd0);
  assign white  = (state == FLASH);

  always_comb begin
    r_nxt = scale(in_red, level);
    g_nxt = scale(in_green, level);
    b_nxt = scale(in_blue, level);
    if (bypass) begin
      r_nxt = in_red;
      g_nxt = in_green;
      b_nxt = in_blue;
    end else if (white) begin
      r_nxt = 4'hF;
      g_nxt = 4'hF;
      b_nxt = 4'hF;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      out_red   <= 4'd0;
      out_green <= 4'd0;
      out_blue  <= 4'd0;
    end else begin
      out_red   <= r_nxt;
      out_green <= g_nxt;
      out_blue  <= b_nxt;
    end
  end

endmodule

// File: tb/tb_palette_fade_ctrl.sv
// Bench for palette_fade_ctrl: tick-count model checked every cycle,
// plus hand-computed literal checks on the key scenarios.
module tb_palette_fade_ctrl;

  localparam int STEP  = 2;
  localparam int FLASH = 4;
`ifdef PALETTE_FADE_TRANSPARENT_EN
  localparam bit TR = 1'b1;
`else
  localparam bit TR = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b1;
  logic       frame_tick = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd = 2'b00;
  logic       cmd_ready;
  logic [3:0] index = 4'd3;
  logic [3:0] in_red = 4'hA, in_green = 4'h8, in_blue = 4'h4;
  logic [3:0] out_red, out_green, out_blue;
  logic [4:0] level;
  logic       busy, done;

  palette_fade_ctrl #(.STEP_FRAMES(STEP), .FLASH_FRAMES(FLASH)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick),
    .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
    .index(index), .in_red(in_red), .in_green(in_green),
    .in_blue(in_blue), .out_red(out_red), .out_green(out_green),
    .out_blue(out_blue), .level(level), .busy(busy), .done(done)
  );

  always #5 Clk = ~Clk;

  int tests = 0;
  int failed = 0;
  int done_cnt = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: mode 0 bright, 1 fade-out, 2 dark, 3 fade-in, 4 flash
  int m_mode = 0;
  int m_n = 0;
  int m_level = 16;
  bit m_done = 0;
  int e_r = 0, e_g = 0, e_b = 0;

  function automatic int sc(input int c, input int l);
    return (c * l) / 16;
  endfunction

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m_mode = 0; m_n = 0; m_level = 16; m_done = 0;
      e_r = 0; e_g = 0; e_b = 0;
    end else begin
      if (TR && index == 0) begin
        e_r = in_red; e_g = in_green; e_b = in_blue;
      end else if (m_mode == 4) begin
        e_r = 15; e_g = 15; e_b = 15;
      end else begin
        e_r = sc(in_red, m_level);
        e_g = sc(in_green, m_level);
        e_b = sc(in_blue, m_level);
      end
      m_done = 0;
      if ((m_mode == 0 || m_mode == 2) && cmd_valid) begin
        m_n = 0;
        if (m_mode == 0 && cmd == 2'b01) m_mode = 1;
        else if (m_mode == 0 && cmd == 2'b11) m_mode = 4;
        else if (m_mode == 2 && cmd == 2'b10) m_mode = 3;
      end else if (frame_tick && m_mode != 0 && m_mode != 2) begin
        m_n++;
        if (m_mode == 1) begin
          m_level = 16 - m_n / STEP;
          if (m_n == 16 * STEP) begin m_mode = 2; m_done = 1; end
        end else if (m_mode == 3) begin
          m_level = m_n / STEP;
          if (m_n == 16 * STEP) begin m_mode = 0; m_done = 1; end
        end else if (m_n == FLASH) begin
          m_mode = 0; m_done = 1;
        end
      end
    end
  end

  always @(negedge Clk) begin
    check("level", 32'(level), 32'(m_level));
    check("cmd_ready", 32'(cmd_ready), 32'(m_mode == 0 || m_mode == 2));
    check("busy", 32'(busy), 32'(!(m_mode == 0 || m_mode == 2)));
    check("done", 32'(done), 32'(m_done));
    check("out", {20'd0, out_red, out_green, out_blue},
          32'((e_r << 8) | (e_g << 4) | e_b));
    if (done === 1'b1) done_cnt++;
  end

  bit vary = 0;
  int vk = 0;
  logic [15:0] vtab [8] = '{16'h3A84, 16'h0FFF, 16'h5123, 16'hF7E9,
                           16'h0C60, 16'h2F0F, 16'h9BBB, 16'h4001};

  task automatic cyc(input bit tk);
    frame_tick = tk;
    if (vary) begin
      {index, in_red, in_green, in_blue} = vtab[vk % 8];
      vk++;
    end
    @(negedge Clk);
    frame_tick = 1'b0;
  endtask

  task automatic tickn(input int k);
    for (int i = 0; i < k; i++) begin
      cyc(1'b1);
      cyc(1'b0);
    end
  endtask

  task automatic set_a84(input logic [3:0] idx);
    vary = 0;
    index = idx; in_red = 4'hA; in_green = 4'h8; in_blue = 4'h4;
  endtask

  int d0;

  initial begin
    #1 Reset_n = 1'b0;
    #3;
    check("rst_level", 32'(level), 32'd16);
    check("rst_out", {20'd0, out_red, out_green, out_blue}, 32'h000);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    check("pass_a84", {20'd0, out_red, out_green, out_blue}, 32'hA84);

    d0 = done_cnt;
    cmd_valid = 1'b1; cmd = 2'b01;
    cyc(1'b0);
    cmd_valid = 1'b0;
    tickn(16);
    check("lvl8", 32'(level), 32'd8);
    check("lvl8_out", {20'd0, out_red, out_green, out_blue}, 32'h542);
    vary = 1;
    tickn(16);
    check("fo_done_once", 32'(done_cnt - d0), 32'd1);
    check("dark_lvl", 32'(level), 32'd0);
    set_a84(4'd3);
    cyc(1'b0); cyc(1'b0);
    check("dark_out", {20'd0, out_red, out_green, out_blue}, 32'h000);
    index = 4'd0;
    cyc(1'b0);
    check("idx0_dark", {20'd0, out_red, out_green, out_blue},
          TR ? 32'hA84 : 32'h000);

    d0 = done_cnt;
    vary = 1;
    cmd_valid = 1'b1; cmd = 2'b10;
    cyc(1'b1);
    cmd_valid = 1'b0;
    tickn(31);
    check("fi_31", 32'(level), 32'd15);
    check("fi_31_busy", 32'(busy), 32'd1);
    tickn(1);
    check("fi_32", 32'(level), 32'd16);
    check("fi_done_once", 32'(done_cnt - d0), 32'd1);

    d0 = done_cnt;
    set_a84(4'd5);
    cmd_valid = 1'b1; cmd = 2'b11;
    cyc(1'b0);
    cmd_valid = 1'b0;
    cyc(1'b0);
    check("flash_fff", {20'd0, out_red, out_green, out_blue}, 32'hFFF);
    tickn(3);
    check("flash_hold", {20'd0, out_red, out_green, out_blue}, 32'hFFF);
    tickn(1);
    check("flash_after", {20'd0, out_red, out_green, out_blue}, 32'hA84);
    check("flash_lvl", 32'(level), 32'd16);
    check("flash_done", 32'(done_cnt - d0), 32'd1);

    d0 = done_cnt;
    cmd_valid = 1'b1; cmd = 2'b01;
    cyc(1'b0);
    cmd = 2'b10;
    vary = 1;
    tickn(32);
    check("held_fi_acc", 32'(busy), 32'd1);
    check("held_lvl0", 32'(level), 32'd0);
    check("held_fo_done", 32'(done_cnt - d0), 32'd1);
    cmd_valid = 1'b0;
    tickn(32);
    check("held_fi_lvl", 32'(level), 32'd16);

    d0 = done_cnt;
    cmd_valid = 1'b1; cmd = 2'b01;
    cyc(1'b0);
    cmd_valid = 1'b0;
    tickn(22);
    check("mid_lvl5", 32'(level), 32'd5);
    #2 Reset_n = 1'b0;
    #1;
    check("arst_lvl", 32'(level), 32'd16);
    check("arst_out", {20'd0, out_red, out_green, out_blue}, 32'h000);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    set_a84(4'd3);
    cyc(1'b0); cyc(1'b0);
    check("arst_nodone", 32'(done_cnt - d0), 32'd0);
    check("arst_pass", {20'd0, out_red, out_green, out_blue}, 32'hA84);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
